alu_cmd_driver: RTL and testbench
=================================

// Module: alu_cmd_driver
// PURPOSE
//  Sequential initiator for the 16-bit combinational ALU (add/sub/encrypt/decrypt).
//  Accepts operation requests on a valid/ready command channel and drives the ALU's
//  instruction/a/b inputs. Samples the ALU result after a programmable settle time and
//  returns it on a valid/ready response channel. Sits between a host/sequencer and the ALU instance.
// PARAMETERS
//  WORD_W      16  operand/result width; must match the ALU
//  SETTLE_CYC  1   cycles the ALU inputs are held before result is sampled; must be >=1
//  CNT_W       8   width of completed-operation counter
// PORTS
//  clk              in   1       single clock; all state updates on posedge
//  rst_n            in   1       asynchronous, active-low reset
//  cmd_valid        in   1       command request
//  cmd_ready        out  1       command accept; high only in IDLE
//  cmd_instr        in   2       00 add, 01 sub, 10 encrypt, 11 decrypt
//  cmd_a            in   WORD_W  operand a
//  cmd_b            in   WORD_W  operand b (key for enc/dec)
//  alu_instruction  out  2       to ALU .instruction (registered)
//  alu_a            out  WORD_W  to ALU .a (registered)
//  alu_b            out  WORD_W  to ALU .b (registered)
//  alu_result       in   WORD_W  from ALU .result
//  rsp_valid        out  1       response available
//  rsp_ready        in   1       response consumed
//  rsp_result       out  WORD_W  captured ALU result
//  rsp_instr        out  2       opcode of this response
//  op_count         out  CNT_W   completed responses, wraps modulo 2^CNT_W
//  chk_err          out  1       sticky round-trip mismatch (ALU_CHECK_EN only, else 0)
// BEHAVIOUR
//  - Reset (rst_n low, async): state=IDLE; all outputs 0 except cmd_ready=1 after release;
//    any in-flight op is dropped with no response.
//  - FSM states: IDLE -> WAIT -> [VERIFY] -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at edge T, register instr/a/b into the alu_* regs.
//    Load the settle counter with SETTLE_CYC-1. Go to WAIT.
//  - WAIT: counter decrements each cycle. At the edge where it is 0 (T+SETTLE_CYC):
//    rsp_result<=alu_result, rsp_instr<=alu_instruction, rsp_valid<=1, go to RESP.
//  - RESP: rsp_valid, rsp_result and rsp_instr are held stable until rsp_ready. On handshake:
//    rsp_valid<=0, op_count<=op_count+1 (wraps 2^CNT_W-1 -> 0), go to IDLE.
//  - Latency is SETTLE_CYC cycles from accept to rsp_valid. Max throughput is one op per
//    SETTLE_CYC+2 cycles when rsp_ready=1.
//  - Command inputs are ignored outside IDLE. alu_* outputs hold their last values after the op completes.
//  - All four opcodes are legal. Add/sub wrap modulo 2^WORD_W (ALU behaviour, not corrected here).
//  - rsp_ready while rsp_valid=0 has no effect.
// CONFIGURATION
//  ALU_CHECK_EN defined:
//    - For opcode 10 (encrypt): at the WAIT exit, save enc result, go to VERIFY.
//    - VERIFY drives alu_instruction=11, alu_a=enc result, alu_b=original key for SETTLE_CYC cycles.
//    - If alu_result != original a, chk_err<=1 (sticky until reset).
//    - rsp_result returns the encrypt result. Encrypt latency becomes 2*SETTLE_CYC.
//  ALU_CHECK_EN undefined: no VERIFY state, no saved operand; chk_err tied 0; all ops use the same latency.
// STRUCTURE
//  - Package alu_pkg: WORD_W localparam; typedef enum logic[1:0] alu_op_e {OP_ADD, OP_SUB, OP_ENC, OP_DEC};
//    typedef enum drv_state_e {S_IDLE, S_WAIT, S_VERIFY, S_RESP}.
//  - No sub-module: single FSM plus datapath registers; the ALU is instantiated by the parent.
// TESTING (bench instantiates alu_cmd_driver + ALU)
//  1. ADD a=10 b=15, rsp_ready=1: rsp_valid 1 cycle after accept, rsp_result=25, rsp_instr=00, op_count=1.
//  2. Back-to-back ADD 10000+2000 then SUB 3000-1500: responses 12000 then 1500,
//     second accept exactly SETTLE_CYC+2 cycles after the first.
//  3. SUB 50-20 with rsp_ready=0 for 5 cycles: rsp_valid stays 1, rsp_result=30 stable, cmd_ready=0.
//     A cmd_valid pulse meanwhile is ignored; one response only after rsp_ready.
//  4. ALU_CHECK_EN, ENC a=A5A5 b=1234: ALU sees 10 then 11 (alu_a=enc result, alu_b=1234).
//     rsp_result = model encrypt value, chk_err=0. Forcing alu_result during VERIFY -> chk_err=1, stays 1.
//  5. rst_n low mid-WAIT with SETTLE_CYC=3: immediately rsp_valid=0, alu_*=0, op_count=0.
//     No response after release; cmd_ready=1.
//  6. 256 completed ops with CNT_W=8: op_count returns to 0; ENC FFFF/0001 then DEC on result recovers FFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU command driver: opcode encoding and driver FSM states.
// Default ALU width lives here so the driver and its parent agree on operand size.
package alu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ENC = 2'b10,
    OP_DEC = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_VERIFY = 2'b10,
    S_RESP   = 2'b11
  } drv_state_e;

endpackage

// File: rtl/alu_cmd_driver.sv
// Sequential initiator for the combinational ALU; ALU_CHECK_EN adds an encrypt round-trip check.
// Latency SETTLE_CYC cycles accept->rsp_valid (2*SETTLE_CYC for checked encrypts).
// cmd_ready only in IDLE; response held stable until rsp_ready.
module alu_cmd_driver #(
  parameter int WORD_W     = alu_pkg::WORD_W,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_instr,
  input  logic [WORD_W-1:0] cmd_a,
  input  logic [WORD_W-1:0] cmd_b,
  output logic [1:0]        alu_instruction,
  output logic [WORD_W-1:0] alu_a,
  output logic [WORD_W-1:0] alu_b,
  input  logic [WORD_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_result,
  output logic [1:0]        rsp_instr,
  output logic [CNT_W-1:0]  op_count,
  output logic              chk_err
);

  import alu_pkg::*;

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYC - 1);

  drv_state_e        state_q, state_d;
  logic [SC_W-1:0]   cnt_q, cnt_d;
  logic [1:0]        instr_q, instr_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic [WORD_W-1:0] rsp_res_q, rsp_res_d;
  logic [1:0]        rsp_instr_q, rsp_instr_d;
  logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;

  logic cmd_hs;
  logic rsp_hs;
  logic settle_done;
  logic go_verify;

`ifdef ALU_CHECK_EN
  logic [WORD_W-1:0] orig_a_q, orig_a_d;
  logic              chk_err_q, chk_err_d;
`endif

  assign cmd_hs      = cmd_valid && cmd_ready;
  assign rsp_hs      = rsp_vld_q && rsp_ready;
  assign settle_done = (cnt_q == '0);
`ifdef ALU_CHECK_EN
  assign go_verify   = (instr_q == OP_ENC);
`else
  assign go_verify   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      instr_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_res_q   <= '0;
      rsp_instr_q <= '0;
      op_cnt_q    <= '0;
`ifdef ALU_CHECK_EN
      orig_a_q    <= '0;
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_res_q   <= rsp_res_d;
      rsp_instr_q <= rsp_instr_d;
      op_cnt_q    <= op_cnt_d;
`ifdef ALU_CHECK_EN
      orig_a_q    <= orig_a_d;
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_hs) state_d = S_WAIT;
      S_WAIT:   if (settle_done) state_d = go_verify ? S_VERIFY : S_RESP;
      S_VERIFY: if (settle_done) state_d = S_RESP;
      S_RESP:   if (rsp_hs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath register updates
  always_comb begin
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_vld_d   = rsp_vld_q;
    rsp_res_d   = rsp_res_q;
    rsp_instr_d = rsp_instr_q;
    op_cnt_d    = op_cnt_q;
`ifdef ALU_CHECK_EN
    orig_a_d    = orig_a_q;
    chk_err_d   = chk_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          instr_d = cmd_instr;
          a_d     = cmd_a;
          b_d     = cmd_b;
          cnt_d   = SC_LOAD;
`ifdef ALU_CHECK_EN
          orig_a_d = cmd_a;
`endif
        end
      end
      S_WAIT: begin
        if (!settle_done) begin
          cnt_d = cnt_q - SC_W'(1);
        end else if (go_verify) begin
          // alu_a keeps the ciphertext through VERIFY and is returned as the response
          instr_d = OP_DEC;
          a_d     = alu_result;
          cnt_d   = SC_LOAD;
        end else begin
          rsp_vld_d   = 1'b1;
          rsp_res_d   = alu_result;
          rsp_instr_d = instr_q;
        end
      end
`ifdef ALU_CHECK_EN
      S_VERIFY: begin
        if (!settle_done) begin
          cnt_d = cnt_q - SC_W'(1);
        end else begin
          rsp_vld_d   = 1'b1;
          rsp_res_d   = a_q;
          rsp_instr_d = OP_ENC;
          if (alu_result != orig_a_q) chk_err_d = 1'b1;
        end
      end
`endif
      S_RESP: begin
        if (rsp_hs) begin
          rsp_vld_d = 1'b0;
          op_cnt_d  = op_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs; cmd_ready is suppressed while reset is asserted
  always_comb begin
    cmd_ready       = (state_q == S_IDLE) && rst_n;
    alu_instruction = instr_q;
    alu_a           = a_q;
    alu_b           = b_q;
    rsp_valid       = rsp_vld_q;
    rsp_result      = rsp_res_q;
    rsp_instr       = rsp_instr_q;
    op_count        = op_cnt_q;
`ifdef ALU_CHECK_EN
    chk_err         = chk_err_q;
`else
    chk_err         = 1'b0;
`endif
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed self-checking bench: two drivers (SETTLE_CYC=1 and 3) each paired with an ALU model.
module tb_alu_cmd_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ALU_CHECK_EN
  localparam int ENC_LAT = 2;
`else
  localparam int ENC_LAT = 1;
`endif

  // ALU model: enc = (a^k)+k, dec = (c-k)^k
  function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return (a ^ b) + b;
      default: return (a - b) ^ b;
    endcase
  endfunction

  // Main DUT, SETTLE_CYC=1
  logic rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, chk_err;
  logic [1:0]  cmd_instr, alu_instruction, rsp_instr;
  logic [15:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
  logic [7:0]  op_count;
  logic        force_en;
  logic [15:0] force_val;

  assign alu_result = force_en ? force_val : alu_f(alu_instruction, alu_a, alu_b);

  alu_cmd_driver #(.WORD_W(16), .SETTLE_CYC(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_instr(cmd_instr), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_instruction(alu_instruction), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_instr(rsp_instr), .op_count(op_count), .chk_err(chk_err)
  );

  // Second DUT, SETTLE_CYC=3
  logic d3_rst_n, d3_cmd_valid, d3_cmd_ready, d3_rsp_valid, d3_rsp_ready, d3_chk_err;
  logic [1:0]  d3_cmd_instr, d3_alu_instruction, d3_rsp_instr;
  logic [15:0] d3_cmd_a, d3_cmd_b, d3_alu_a, d3_alu_b, d3_alu_result, d3_rsp_result;
  logic [7:0]  d3_op_count;

  assign d3_alu_result = alu_f(d3_alu_instruction, d3_alu_a, d3_alu_b);

  alu_cmd_driver #(.WORD_W(16), .SETTLE_CYC(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(d3_rst_n), .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready),
    .cmd_instr(d3_cmd_instr), .cmd_a(d3_cmd_a), .cmd_b(d3_cmd_b),
    .alu_instruction(d3_alu_instruction), .alu_a(d3_alu_a), .alu_b(d3_alu_b),
    .alu_result(d3_alu_result), .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready),
    .rsp_result(d3_rsp_result), .rsp_instr(d3_rsp_instr), .op_count(d3_op_count), .chk_err(d3_chk_err)
  );

  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for cmd_ready, step through the accepting edge
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input string tag);
    int n = 0;
    cmd_instr = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin step(); n++; end
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    step();
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int lat, input string tag);
    int n = 0;
    while (!rsp_valid && n < 50) begin step(); n++; end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(lat));
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic recv(input logic [15:0] res, input logic [1:0] op, input int lat, input string tag);
    wait_rsp(lat, tag);
    chk({tag, "_result"}, 32'(rsp_result), 32'(res));
    chk({tag, "_instr"}, 32'(rsp_instr), 32'(op));
    ack();
  endtask

  initial begin
    int a1;
    int n;
    logic seen;
    rst_n = 1'b0; d3_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_instr = 2'b00; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    d3_cmd_valid = 1'b0; d3_cmd_instr = 2'b00; d3_cmd_a = '0; d3_cmd_b = '0; d3_rsp_ready = 1'b0;
    force_en = 1'b0; force_val = '0;

    // Reset state
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_chk_err", 32'(chk_err), 32'd0);
    rst_n = 1'b1; d3_rst_n = 1'b1;
    step();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // 1. ADD 10+15
    send(2'b00, 16'd10, 16'd15, "t1");
    chk("t1_alu_a", 32'(alu_a), 32'd10);
    chk("t1_busy", 32'(cmd_ready), 32'd0);
    recv(16'd25, 2'b00, 1, "t1");
    chk("t1_op_count", 32'(op_count), 32'd1);
    chk("t1_vld_drop", 32'(rsp_valid), 32'd0);

    // 2. Back-to-back ADD then SUB
    send(2'b00, 16'd10000, 16'd2000, "t2a");
    a1 = acc_cyc;
    recv(16'd12000, 2'b00, 1, "t2a");
    send(2'b01, 16'd3000, 16'd1500, "t2b");
    chk("t2_accept_gap", 32'(acc_cyc - a1), 32'd3);
    recv(16'd1500, 2'b01, 1, "t2b");
    chk("t2_op_count", 32'(op_count), 32'd3);

    // 3. Backpressure: response held, stray command ignored
    send(2'b01, 16'd50, 16'd20, "t3");
    wait_rsp(1, "t3");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin cmd_valid = 1'b1; cmd_instr = 2'b00; cmd_a = 16'd1; cmd_b = 16'd1; end
      if (i == 2) cmd_valid = 1'b0;
      chk("t3_hold_vld", 32'(rsp_valid), 32'd1);
      chk("t3_hold_res", 32'(rsp_result), 32'd30);
      chk("t3_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    chk("t3_alu_a_kept", 32'(alu_a), 32'd50);
    ack();
    chk("t3_op_count", 32'(op_count), 32'd4);
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); seen = seen | rsp_valid; end
    rsp_ready = 1'b0;
    chk("t3_no_extra_rsp", 32'(seen), 32'd0);
    chk("t3_op_count_final", 32'(op_count), 32'd4);

`ifdef ALU_CHECK_EN
    // 4. Encrypt round-trip check
    send(2'b10, 16'hA5A5, 16'h1234, "t4");
    chk("t4_enc_instr", 32'(alu_instruction), 32'd2);
    chk("t4_enc_a", 32'(alu_a), 32'hA5A5);
    step();
    chk("t4_dec_instr", 32'(alu_instruction), 32'd3);
    chk("t4_dec_a", 32'(alu_a), 32'hC9C5);
    chk("t4_dec_b", 32'(alu_b), 32'h1234);
    chk("t4_mid_vld", 32'(rsp_valid), 32'd0);
    recv(16'hC9C5, 2'b10, 2, "t4");
    chk("t4_chk_ok", 32'(chk_err), 32'd0);
    send(2'b10, 16'hA5A5, 16'h1234, "t4f");
    step();
    force_en = 1'b1; force_val = 16'h0000;
    step();
    force_en = 1'b0;
    chk("t4_chk_set", 32'(chk_err), 32'd1);
    ack();
    send(2'b00, 16'd1, 16'd1, "t4g");
    recv(16'd2, 2'b00, 1, "t4g");
    chk("t4_chk_sticky", 32'(chk_err), 32'd1);
`endif

    // 5. Reset mid-WAIT on the SETTLE_CYC=3 driver
    d3_cmd_instr = 2'b00; d3_cmd_a = 16'd7; d3_cmd_b = 16'd8; d3_cmd_valid = 1'b1;
    chk("t5_cmd_ready", 32'(d3_cmd_ready), 32'd1);
    step();
    d3_cmd_valid = 1'b0;
    a1 = cyc;
    n = 0;
    while (!d3_rsp_valid && n < 20) begin step(); n++; end
    chk("t5_rsp_valid", 32'(d3_rsp_valid), 32'd1);
    chk("t5_latency", 32'(cyc - a1), 32'd3);
    chk("t5_result", 32'(d3_rsp_result), 32'd15);
    d3_rsp_ready = 1'b1; step(); d3_rsp_ready = 1'b0;
    chk("t5_op_count", 32'(d3_op_count), 32'd1);
    d3_cmd_instr = 2'b01; d3_cmd_a = 16'd100; d3_cmd_b = 16'd1; d3_cmd_valid = 1'b1;
    step();
    d3_cmd_valid = 1'b0;
    step();
    chk("t5_in_wait_vld", 32'(d3_rsp_valid), 32'd0);
    chk("t5_in_wait_alu_a", 32'(d3_alu_a), 32'd100);
    #2 d3_rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", 32'(d3_rsp_valid), 32'd0);
    chk("t5_rst_alu_a", 32'(d3_alu_a), 32'd0);
    chk("t5_rst_alu_instr", 32'(d3_alu_instruction), 32'd0);
    chk("t5_rst_res", 32'(d3_rsp_result), 32'd0);
    chk("t5_rst_op_count", 32'(d3_op_count), 32'd0);
    #2 d3_rst_n = 1'b1;
    step();
    chk("t5_release_ready", 32'(d3_cmd_ready), 32'd1);
    d3_rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); seen = seen | d3_rsp_valid; end
    d3_rsp_ready = 1'b0;
    chk("t5_no_rsp", 32'(seen), 32'd0);
    chk("t5_op_count_after", 32'(d3_op_count), 32'd0);

    // 6. Counter wrap after 256 ops, then ENC/DEC round trip
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    cmd_instr = 2'b00; cmd_a = 16'd3; cmd_b = 16'd4; cmd_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 767; i++) step();
    chk("t6_count_255", 32'(op_count), 32'd255);
    chk("t6_last_res", 32'(rsp_result), 32'd7);
    step();
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk("t6_count_wrap", 32'(op_count), 32'd0);
    chk("t6_idle_ready", 32'(cmd_ready), 32'd1);
    send(2'b10, 16'hFFFF, 16'h0001, "t6e");
    recv(16'hFFFF, 2'b10, ENC_LAT, "t6e");
    send(2'b11, 16'hFFFF, 16'h0001, "t6d");
    recv(16'hFFFF, 2'b11, 1, "t6d");
    chk("t6_count_2", 32'(op_count), 32'd2);
    chk("t6_chk_err", 32'(chk_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
